// File: rtl/serial_nbit_subtractor.sv
// Bit-serial unsigned subtractor: diff = a - b - bin, LSB first, one bit per clock,
// with start/busy/done handshake. Define SUB_OVF_EN to add the signed-overflow output ovf.
module serial_nbit_subtractor #(
    parameter int P = 6
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         start,
    input  logic [P-1:0] a,
    input  logic [P-1:0] b,
    input  logic         bin,
    output logic         busy,
    output logic         done,
    output logic [P-1:0] diff,
    output logic         bout
`ifdef SUB_OVF_EN
    ,
    output logic         ovf
`endif
);

    localparam int CW = $clog2(P);
    localparam logic [CW-1:0] LAST = CW'(P - 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t          state_r;
    state_t          state_s;
    logic            accept_s;
    logic            last_s;
    logic            d_bit_s;
    logic            br_next_s;
    logic [P-1:0]    full_s;
    logic [P-1:0]    a_sr_r;
    logic [P-1:0]    b_sr_r;
    logic [P-2:0]    d_sr_r;
    logic            br_r;
    logic [CW-1:0]   cnt_r;
    logic            busy_r;
    logic            done_r;
    logic [P-1:0]    diff_r;
    logic            bout_r;
`ifdef SUB_OVF_EN
    logic            a_msb_r;
    logic            b_msb_r;
    logic            ovf_r;
`endif

    // One full-subtractor bit slice on the current operand LSBs.
    always_comb begin
        d_bit_s   = a_sr_r[0] ^ b_sr_r[0] ^ br_r;
        br_next_s = (~a_sr_r[0] & b_sr_r[0]) | (~(a_sr_r[0] ^ b_sr_r[0]) & br_r);
        full_s    = {d_bit_s, d_sr_r};
    end

    // Next-state decode; accept_s marks an edge that loads a new operation.
    always_comb begin
        state_s  = state_r;
        accept_s = 1'b0;
        last_s   = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (start) begin
                    state_s  = ST_RUN;
                    accept_s = 1'b1;
                end else begin
                    state_s  = ST_IDLE;
                end
            end
            ST_RUN: begin
                if (cnt_r == LAST) begin
                    state_s = ST_DONE;
                    last_s  = 1'b1;
                end else begin
                    state_s = ST_RUN;
                end
            end
            ST_DONE: begin
                if (start) begin
                    state_s  = ST_RUN;
                    accept_s = 1'b1;
                end else begin
                    state_s  = ST_IDLE;
                end
            end
            default: begin
                state_s = ST_IDLE;
            end
        endcase
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Operand/result shift registers, borrow flop and bit counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_sr_r <= {P{1'b0}};
            b_sr_r <= {P{1'b0}};
            d_sr_r <= {(P-1){1'b0}};
            br_r   <= 1'b0;
            cnt_r  <= {CW{1'b0}};
        end else if (accept_s) begin
            a_sr_r <= a;
            b_sr_r <= b;
            d_sr_r <= {(P-1){1'b0}};
            br_r   <= bin;
            cnt_r  <= {CW{1'b0}};
        end else if (state_r == ST_RUN) begin
            a_sr_r <= {1'b0, a_sr_r[P-1:1]};
            b_sr_r <= {1'b0, b_sr_r[P-1:1]};
            d_sr_r <= full_s[P-1:1];
            br_r   <= br_next_s;
            cnt_r  <= cnt_r + CW'(1);
        end
    end

    // Registered handshake and result; diff/bout change only when entering DONE.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy_r <= 1'b0;
            done_r <= 1'b0;
            diff_r <= {P{1'b0}};
            bout_r <= 1'b0;
        end else begin
            busy_r <= (state_s == ST_RUN);
            done_r <= (state_s == ST_DONE);
            if (last_s) begin
                diff_r <= full_s;
                bout_r <= br_next_s;
            end
        end
    end

`ifdef SUB_OVF_EN
    // Operand sign bits are kept aside because the operand registers shift them away.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_msb_r <= 1'b0;
            b_msb_r <= 1'b0;
            ovf_r   <= 1'b0;
        end else begin
            if (accept_s) begin
                a_msb_r <= a[P-1];
                b_msb_r <= b[P-1];
            end
            if (last_s) begin
                ovf_r <= (a_msb_r != b_msb_r) && (d_bit_s != a_msb_r);
            end
        end
    end

    assign ovf = ovf_r;
`endif

    assign busy = busy_r;
    assign done = done_r;
    assign diff = diff_r;
    assign bout = bout_r;

endmodule

// File: doc/serial_nbit_subtractor.md
Name: serial_nbit_subtractor

Overview:
- Bit-serial, multi-cycle N-bit subtractor computing diff = a - b - bin, LSB first, one bit per clock.
- Inverse-direction companion to the team's combinational N-bit full adder; shares its operand width and its carry/borrow conventions.
- Built for area-constrained datapaths. Uses a start/busy/done handshake and holds its result until the next accepted operation.

Parameters:
- P, 6, operand and result width in bits (P >= 2).

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- start  input  1  request a new operation; sampled only when accepting (IDLE or DONE)
- a  input  P  minuend; sampled on the accepting edge only
- b  input  P  subtrahend; sampled on the accepting edge only
- bin  input  1  borrow-in; sampled on the accepting edge only
- busy  output  1  high while in RUN
- done  output  1  one-cycle pulse when the result becomes valid
- diff  output  P  result (a - b - bin) mod 2^P
- bout  output  1  borrow-out; 1 when a < b + bin (unsigned)

Behaviour:
- Reset (rst_n low, asynchronous): state=IDLE; busy=0, done=0, diff=0, bout=0; internal shift registers, borrow flop and counter cleared. Reset mid-operation aborts the operation; no done pulse is produced.
- FSM states: IDLE, RUN, DONE.
- IDLE: if start=1 at an edge, latch a, b and bin into the operand shift registers and borrow flop; counter=0; go to RUN. Otherwise stay in IDLE.
- RUN: busy=1. Each edge processes the current LSBs x=a_sr[0], y=b_sr[0] with borrow br:
  - d = x^y^br
  - br_next = (~x&y) | (~(x^y)&br)
  - d shifts into the diff shift register from the MSB side; operand registers shift right.
  - Counter increments. On the edge where counter reaches P-1, go to DONE.
- DONE: done=1 for exactly one cycle; diff and bout are updated on the edge entering DONE.
  - start=1 in DONE: accept a new operation exactly as in IDLE and go directly to RUN.
  - start=0 in DONE: go to IDLE.
- Latency: start accepted at edge k; done high in the cycle after edge k+P. Minimum issue interval is P+1 cycles.
- Result hold: diff and bout hold their value until the next result is written. The diff output register changes only on entry to DONE, never during RUN; intermediate bits live in an internal shift register.
- start while busy=1 is ignored; operand changes during RUN have no effect.
- Arithmetic is unsigned modulo 2^P.
- Wrap-around: 0 - 1 gives all ones with bout=1.
- Equal operands with bin=0 give 0 with bout=0.

Optional Feature:
- Macro: SUB_OVF_EN
- Defined: adds output port ovf (1 bit), reset 0, updated together with diff on entry to DONE.
  - ovf = (a[P-1] != b[P-1]) && (diff[P-1] != a[P-1]), using latched operand MSBs (two's-complement signed overflow).
- Undefined: no ovf port and no related logic; all other behaviour is identical.

Test Plan:
- Reset: rst_n=0 -> busy=0, done=0, diff=000000, bout=0. Release, start=1 with a=000011, b=000010, bin=1 -> done pulse 7 cycles after the accepting edge; diff=000000, bout=0.
- Wrap: a=000000, b=000001, bin=0 -> diff=111111, bout=1; ovf=0 when SUB_OVF_EN is defined.
- Signed overflow: a=010101, b=101010, bin=0 -> diff=101011, bout=1; ovf=1 when SUB_OVF_EN is defined.
- Ignore while busy: start a=001000, b=000011, bin=0; two cycles later pulse start with a=111111, b=000000 -> single done pulse; diff=000101, bout=0; busy stays 1 throughout RUN.
- Reset mid-operation: start a=100111, b=000001; assert rst_n=0 after 3 cycles -> outputs 0 immediately, no done pulse. Release, start a=000111, b=000111, bin=0 -> diff=000000, bout=0.
- Back-to-back: start held high with the operand pair changing each accept -> done pulses every 7 cycles; each diff matches its own operands; busy low only during the DONE cycle.
